// File: rtl/spio_uart_pkg.sv
// Shared definitions for the spio UART link: FSM state encoding, width helper and frame length.
package spio_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r++;
            end
        end
        return r;
    endfunction

    // Serial bits per frame; the receiver uses the same rule to size its frame timeout.
    function automatic int frame_bits(input int num_data, input int num_stop, input int parity);
        return 1 + num_data + parity + num_stop;
    endfunction

endpackage

// File: rtl/spio_uart_baud_gen.sv
// Bit-period counter: counts 0..CLOCKS_PER_BIT-1 and pulses tick_out on the last cycle of each bit.
module spio_uart_baud_gen
    import spio_uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 868
) (
    input  logic CLK_IN,
    input  logic RESET_IN,
    input  logic restart_in,
    output logic tick_out
);

    localparam int CW = clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q + CW'(1);
        if (restart_in || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A restart realigns the period, so the stale end-of-period is suppressed.
    assign tick_out = (count_q == LAST) && !restart_in;

endmodule

// File: rtl/spio_uart_tx.sv
// spio UART transmitter: valid/ready byte in, LSB-first start/data/[parity]/stop frames out.
// Optional parity bit enabled by defining SPIO_UART_TX_PARITY_EN.
module spio_uart_tx
    import spio_uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT  = 868,
    parameter int NUM_DATA_BITS   = 8,
    parameter int NUM_STOP_BITS   = 1,
    parameter int PARITY_ODD      = 0,
    parameter int NUM_SYNC_STAGES = 2
) (
    input  logic       CLK_IN,
    input  logic       RESET_IN,
    input  logic [7:0] DATA_IN,
    input  logic       VLD_IN,
    output logic       RDY_OUT,
    input  logic       CTS_IN,
    output logic       TX_OUT,
    output logic       BUSY_OUT
);

    localparam int IW = clog2(NUM_DATA_BITS);
    localparam logic [IW-1:0] LAST_DATA = IW'(NUM_DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(NUM_STOP_BITS - 1);

    uart_state_t                state_q, state_d;
    logic [NUM_SYNC_STAGES-1:0] cts_sync_q, cts_sync_d;
    logic [7:0]                 shift_q, shift_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic                       tx_q, tx_d;
    logic                       rdy_q, rdy_d;
    logic                       busy_q, busy_d;
`ifdef SPIO_UART_TX_PARITY_EN
    logic                       par_q, par_d;
`endif
    logic                       tick;
    logic                       restart;
    logic                       cts_s;
    logic                       accept;

    assign cts_s  = cts_sync_q[NUM_SYNC_STAGES-1];
    assign accept = VLD_IN && rdy_q;

    always_comb begin
        cts_sync_d    = cts_sync_q << 1;
        cts_sync_d[0] = CTS_IN;
    end

    spio_uart_baud_gen #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud_gen (
        .CLK_IN    (CLK_IN),
        .RESET_IN  (RESET_IN),
        .restart_in(restart),
        .tick_out  (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        restart = 1'b0;
`ifdef SPIO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = ST_START;
                    shift_d = DATA_IN;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    restart = 1'b1;
`ifdef SPIO_UART_TX_PARITY_EN
                    par_d   = (^DATA_IN[NUM_DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
`ifdef SPIO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef SPIO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (idx_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Ready/busy are registered from the next state so they line up with TX_OUT.
        rdy_d  = (state_d == ST_IDLE) && cts_s;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q    <= ST_IDLE;
            cts_sync_q <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            tx_q       <= 1'b1;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SPIO_UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cts_sync_q <= cts_sync_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
`ifdef SPIO_UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign TX_OUT   = tx_q;
    assign RDY_OUT  = rdy_q;
    assign BUSY_OUT = busy_q;

endmodule

// File: tb/tb_spio_uart_tx.sv
// Directed/randomized bench for spio_uart_tx with a frame-level reference model.
module tb_spio_uart_tx;

    localparam int CPB   = 4;
    localparam int NDB   = 8;
    localparam int NSTOP = 1;
    localparam int NSS   = 2;
    localparam int PODD  = 0;
`ifdef SPIO_UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FBITS = 1 + NDB + P + NSTOP;
    localparam int FCYC  = FBITS * CPB;

    logic       CLK_IN   = 1'b0;
    logic       RESET_IN = 1'b1;
    logic [7:0] DATA_IN  = 8'h00;
    logic       VLD_IN   = 1'b0;
    logic       CTS_IN   = 1'b1;
    logic       RDY_OUT;
    logic       TX_OUT;
    logic       BUSY_OUT;

    int checks = 0;
    int errors = 0;

    always #5 CLK_IN = ~CLK_IN;

    spio_uart_tx #(
        .CLOCKS_PER_BIT (CPB),
        .NUM_DATA_BITS  (NDB),
        .NUM_STOP_BITS  (NSTOP),
        .PARITY_ODD     (PODD),
        .NUM_SYNC_STAGES(NSS)
    ) dut (
        .CLK_IN  (CLK_IN),
        .RESET_IN(RESET_IN),
        .DATA_IN (DATA_IN),
        .VLD_IN  (VLD_IN),
        .RDY_OUT (RDY_OUT),
        .CTS_IN  (CTS_IN),
        .TX_OUT  (TX_OUT),
        .BUSY_OUT(BUSY_OUT)
    );

    // Expected line level for serial bit k of the frame carrying byte d.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        int ones;
        if (k == 0) return 1'b0;
        if (k <= NDB) return d[k-1];
        if (P == 1 && k == NDB + 1) begin
            ones = 0;
            for (int b = 0; b < NDB; b++) ones += int'(d[b]);
            return ((ones % 2) == 1) ^ (PODD != 0);
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_accept();
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK_IN);
            if (RDY_OUT === 1'b1 && VLD_IN) begin
                @(posedge CLK_IN);
                return;
            end
        end
        chk("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic check_frame(input logic [7:0] d, input int cts_drop_at);
        for (int i = 0; i < FCYC; i++) begin
            @(negedge CLK_IN);
            chk($sformatf("tx_d%02h_c%0d", d, i), TX_OUT, exp_bit(d, i / CPB));
            if (i == 0) begin
                chk("busy_in_frame", BUSY_OUT, 1'b1);
                chk("rdy_in_frame", RDY_OUT, 1'b0);
            end
            if (i == cts_drop_at) CTS_IN = 1'b0;
        end
    endtask

    task automatic post_frame(input logic exp_rdy, input logic keep, input logic [7:0] next);
        @(negedge CLK_IN);
        chk("rdy_after_frame", RDY_OUT, exp_rdy);
        chk("busy_after_frame", BUSY_OUT, 1'b0);
        chk("tx_idle_after_frame", TX_OUT, 1'b1);
        if (keep) DATA_IN = next;
        else VLD_IN = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] d2;

        // Reset state and CTS latency out of reset
        RESET_IN = 1'b1;
        repeat (3) @(negedge CLK_IN);
        chk("reset_tx", TX_OUT, 1'b1);
        chk("reset_rdy", RDY_OUT, 1'b0);
        chk("reset_busy", BUSY_OUT, 1'b0);
        RESET_IN = 1'b0;
        repeat (2) @(negedge CLK_IN);
        chk("rdy_before_sync", RDY_OUT, 1'b0);
        @(negedge CLK_IN);
        chk("rdy_after_sync", RDY_OUT, 1'b1);

        // Single byte 0xA5 then idle with no duplicate
        DATA_IN = 8'hA5;
        VLD_IN  = 1'b1;
        wait_accept();
        check_frame(8'hA5, -1);
        post_frame(1'b1, 1'b0, 8'h00);
        repeat (8) begin
            @(negedge CLK_IN);
            chk("idle_no_dup_tx", TX_OUT, 1'b1);
            chk("idle_no_dup_busy", BUSY_OUT, 1'b0);
        end

        // Random single bytes
        repeat (4) begin
            d       = 8'($urandom);
            DATA_IN = d;
            VLD_IN  = 1'b1;
            wait_accept();
            check_frame(d, -1);
            post_frame(1'b1, 1'b0, 8'h00);
        end

        // Back-to-back 0x00 then 0xFF, then a random pair
        DATA_IN = 8'h00;
        VLD_IN  = 1'b1;
        wait_accept();
        check_frame(8'h00, -1);
        post_frame(1'b1, 1'b1, 8'hFF);
        @(posedge CLK_IN);
        check_frame(8'hFF, -1);
        d  = 8'($urandom);
        post_frame(1'b1, 1'b1, d);
        @(posedge CLK_IN);
        check_frame(d, -1);
        d2 = 8'($urandom);
        post_frame(1'b1, 1'b1, d2);
        @(posedge CLK_IN);
        check_frame(d2, -1);
        post_frame(1'b1, 1'b0, 8'h00);

        // Flow control: held off, then CTS drop mid-frame
        CTS_IN = 1'b0;
        repeat (4) @(negedge CLK_IN);
        d       = 8'($urandom);
        DATA_IN = d;
        VLD_IN  = 1'b1;
        repeat (8) begin
            @(negedge CLK_IN);
            chk("cts_low_rdy", RDY_OUT, 1'b0);
            chk("cts_low_tx", TX_OUT, 1'b1);
            chk("cts_low_busy", BUSY_OUT, 1'b0);
        end
        CTS_IN = 1'b1;
        wait_accept();
        check_frame(d, 8);
        d2 = 8'($urandom);
        post_frame(1'b0, 1'b1, d2);
        repeat (6) begin
            @(negedge CLK_IN);
            chk("cts_wait_rdy", RDY_OUT, 1'b0);
            chk("cts_wait_tx", TX_OUT, 1'b1);
        end
        CTS_IN = 1'b1;
        wait_accept();
        check_frame(d2, -1);
        post_frame(1'b1, 1'b0, 8'h00);

        // Reset during data bit 3, then 0x3C frames cleanly
        d       = 8'($urandom) & 8'hF7;
        DATA_IN = d;
        VLD_IN  = 1'b1;
        wait_accept();
        for (int i = 0; i <= 4 * CPB + 1; i++) begin
            @(negedge CLK_IN);
            chk($sformatf("pre_reset_tx_c%0d", i), TX_OUT, exp_bit(d, i / CPB));
        end
        #1;
        RESET_IN = 1'b1;
        VLD_IN   = 1'b0;
        #1;
        chk("midframe_reset_tx", TX_OUT, 1'b1);
        chk("midframe_reset_busy", BUSY_OUT, 1'b0);
        chk("midframe_reset_rdy", RDY_OUT, 1'b0);
        @(negedge CLK_IN);
        RESET_IN = 1'b0;
        repeat (4) @(negedge CLK_IN);
        chk("post_reset_tx_idle", TX_OUT, 1'b1);
        DATA_IN = 8'h3C;
        VLD_IN  = 1'b1;
        wait_accept();
        check_frame(8'h3C, -1);
        post_frame(1'b1, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
